// File: rtl/pqbp_upd_scheduler.sv
// Gshare update scheduler: queues resolved branches and issues them to the
// predictor update port, bubbling when back-to-back records share a BHT index.
module pqbp_upd_scheduler #(
  parameter int GHRW    = 8,
  parameter int BHT_IDW = 6,
  parameter int BPCW    = BHT_IDW + 2,
  parameter int QDEPTH  = 4
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic            i_res_valid,
  output logic            o_res_ready,
  input  logic [BPCW-1:0] i_res_pc,
  input  logic [GHRW-1:0] i_res_ghr,
  input  logic            i_res_btaken,
  input  logic            i_issue_en,
  input  logic            i_clr,
  output logic            o_upd_ghr,
  output logic            o_upd_bht,
  output logic [BPCW-1:0] o_upd_idx_pc,
  output logic [GHRW-1:0] o_upd_idx_ghr,
  output logic            o_actual_btaken,
  output logic            o_empty,
  output logic [15:0]     o_bubble_cnt
);

  localparam int PW = $clog2(QDEPTH);
  localparam int RW = BPCW + GHRW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUBBLE
  } state_t;

  logic [RW-1:0]      mem [QDEPTH];
  logic [PW-1:0]      wptr;
  logic [PW-1:0]      rptr;
  logic [PW:0]        count;
  state_t             state;
  logic               last_vld;
  logic [BHT_IDW-1:0] last_idx;

  logic               full;
  logic               push;
  logic               can_issue;
  logic               hazard;
  logic               pop;
  logic               bubble;
  logic [BPCW-1:0]    head_pc;
  logic [GHRW-1:0]    head_ghr;
  logic               head_bt;
  logic [BHT_IDW-1:0] head_idx;

  function automatic logic [BHT_IDW-1:0] hash(
    input logic [BPCW-1:0] pc,
    input logic [GHRW-1:0] ghr
  );
    logic [BHT_IDW-1:0] h;
    h = pc[BPCW-1:2];
    for (int i = 0; i < GHRW; i++) begin
      h[i % BHT_IDW] = h[i % BHT_IDW] ^ ghr[i];
    end
    return h;
  endfunction

  assign {head_pc, head_ghr, head_bt} = mem[rptr];
  assign head_idx = hash(head_pc, head_ghr);

  // count never exceeds QDEPTH, so its MSB alone flags full
  assign full        = count[PW];
  assign o_res_ready = ~full;
  assign o_empty     = (count == '0);

  assign push      = i_res_valid & ~full & ~i_clr;
  assign can_issue = ~o_empty & i_issue_en & ~i_clr;
  assign hazard    = last_vld & (state != BUBBLE)
                   & (head_idx == last_idx);
  assign pop       = can_issue & ~hazard;
  assign bubble    = can_issue & hazard;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {i_res_pc, i_res_ghr, i_res_btaken};
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wptr            <= '0;
      rptr            <= '0;
      count           <= '0;
      state           <= IDLE;
      last_vld        <= 1'b0;
      last_idx        <= '0;
      o_upd_ghr       <= 1'b0;
      o_upd_bht       <= 1'b0;
      o_upd_idx_pc    <= '0;
      o_upd_idx_ghr   <= '0;
      o_actual_btaken <= 1'b0;
      o_bubble_cnt    <= '0;
    end else begin
      if (i_clr) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + PW'(1);
        if (pop)  rptr <= rptr + PW'(1);
        if (push && !pop) count <= count + (PW+1)'(1);
        if (pop && !push) count <= count - (PW+1)'(1);
      end

      if (i_clr)       state <= IDLE;
      else if (bubble) state <= BUBBLE;
      else if (pop)    state <= ISSUE;
      else             state <= IDLE;

      last_vld <= pop;
      if (pop) last_idx <= head_idx;

      if (bubble && o_bubble_cnt != 16'hFFFF) begin
        o_bubble_cnt <= o_bubble_cnt + 16'd1;
      end

      o_upd_ghr <= pop;
      o_upd_bht <= pop;
      if (pop) begin
        o_upd_idx_pc    <= head_pc;
        o_upd_idx_ghr   <= head_ghr;
        o_actual_btaken <= head_bt;
      end
    end
  end

endmodule

// File: doc/pqbp_upd_scheduler.md
# pqbp_upd_scheduler

Branch-resolution update scheduler for the Gshare predictor. It sits between the execute-stage branch resolution logic and the predictor's update port (`i_upd_ghr`, `i_upd_bht`, `i_upd_idx_pc`, `i_upd_idx_ghr`, `i_actual_btaken`). It buffers resolved-branch records in a small FIFO and issues them one per cycle. The BHT update is read-modify-write (read old counter in cycle N, write in N+1), so the block inserts a one-cycle bubble whenever the next record hashes to the same BHT index as the record issued in the previous cycle; this avoids the stale-read hazard.

## Interface
Parameters:
- `GHRW`, 8: GHR width.
- `BHT_IDW`, 6: BHT index width.
- `BPCW`, `BHT_IDW+2`: PC bits carried per record.
- `QDEPTH`, 4: FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock.
- `aresetn`  in  1  asynchronous, active-low reset.
- `i_res_valid`  in  1  resolved branch record valid.
- `o_res_ready`  out  1  record accepted when `i_res_valid & o_res_ready`; equals `~full`.
- `i_res_pc`  in  `BPCW`  lower PC bits of resolved branch.
- `i_res_ghr`  in  `GHRW`  GHR snapshot used at prediction.
- `i_res_btaken`  in  1  actual outcome.
- `i_issue_en`  in  1  issue enable; 0 holds the queue (accept continues while not full).
- `i_clr`  in  1  synchronous clear: empties FIFO and drops the in-flight index.
- `o_upd_ghr`  out  1  GHR shift pulse.
- `o_upd_bht`  out  1  BHT update pulse; always equal to `o_upd_ghr`.
- `o_upd_idx_pc`  out  `BPCW`  issued record PC.
- `o_upd_idx_ghr`  out  `GHRW`  issued record GHR snapshot.
- `o_actual_btaken`  out  1  issued record outcome.
- `o_empty`  out  1  FIFO empty.
- `o_bubble_cnt`  out  16  saturating count of hazard bubbles.

## Operation
- **FIFO:** `QDEPTH` entries, each `{pc, ghr, btaken}`. Write and read pointers are `log2(QDEPTH)` bits and wrap modulo `QDEPTH`. Occupancy counter is `log2(QDEPTH)+1` bits.
- **Push and pop:** a push occurs on `i_res_valid & o_res_ready`. The head can pop in the same cycle.
  - When full, `o_res_ready` is 0 even if a pop occurs in that cycle (no pass-through).
- **Hash:** identical to the predictor's.
  - `idx = pc[BPCW-1:2] ^ fold(ghr)`.
  - `fold` XORs `ghr[i]` into bit `i mod BHT_IDW`, for all `i`.
- **State machine:** IDLE, ISSUE, BUBBLE. State and `last_idx` are registers.
  - **IDLE:** FIFO empty or `i_issue_en=0`. Go to ISSUE when the FIFO is non-empty and `i_issue_en=1`.
  - **ISSUE** (cycle with FIFO non-empty and `i_issue_en=1`):
    - If the previous cycle issued (`last_vld=1`) and `hash(head)==last_idx`, do not pop. Go to BUBBLE and increment `o_bubble_cnt`, saturating at 16'hFFFF.
    - Otherwise pop the head, assert the `o_upd_*` outputs, set `last_idx=hash(head)` and `last_vld=1`.
  - **BUBBLE:** lasts one cycle, with `last_vld=0`. The next cycle issues the head unconditionally.
  - Any cycle without an issue clears `last_vld`.
- **`i_clr`:**
  - Pointers and count go to 0 and `last_vld` to 0. State goes to IDLE and no issue occurs that cycle.
  - A push in the same cycle is dropped.
  - `o_bubble_cnt` is retained.
- **Output registering:** `o_upd_*` are registered. The issue decision in cycle N appears on the outputs in N+1, as a single-cycle pulse per record. Payload outputs hold their last value when not pulsing.

## Timing
- **Reset values:** all outputs 0 except `o_empty=1` and `o_res_ready=1`; state IDLE, `last_vld=0`.
- **Latency:** a record pushed at edge N is issued on the outputs at edge N+2 at the earliest (FIFO write, issue register).
- **Throughput:** one record per cycle when consecutive indices differ. Two cycles per record for same-index back-to-back records.
- **Ordering:** records are issued strictly in FIFO order. A bubble never reorders.
- **`i_issue_en` deassertion:** takes effect on the next issue decision. A pulse already registered still appears.
- **Reset mid-operation:** asynchronous. FIFO contents are lost and outputs drop immediately.

## Test plan
- **Basic issue:** reset, then push `pc=8'h14`, `ghr=8'h00`, `btaken=1` → one cycle of `o_upd_ghr=o_upd_bht=1`, `o_upd_idx_pc=8'h14`, `o_actual_btaken=1`, two cycles after the push; `o_empty=1` afterwards.
- **Same-index hazard:** push `pc=8'h14`/`ghr=0` twice back-to-back → pulses two cycles apart (index 5 both), `o_bubble_cnt=1`.
- **Fold collision:** push `pc=8'h18`/`ghr=8'h40` (idx 7), then `pc=8'h1C`/`ghr=8'h00` (idx 7) → one bubble. Then `pc=8'h20`/`ghr=0` (idx 8) → issues back-to-back with no bubble.
- **Full and ready:** `i_issue_en=0`, push 4 records → `o_res_ready=0`, and a 5th valid is not accepted. Set `i_issue_en=1` → all 4 issue in order and `o_res_ready` rises the cycle after the first pop.
- **Clear:** `i_clr` pulse with 3 queued records → no further `o_upd_*` pulses, `o_empty=1`. A subsequent push with the same index as the last issued record issues without a bubble.
- **Reset mid-stream:** assert `aresetn=0` during a pulse → outputs go to 0 asynchronously, and after release the FIFO is empty.
